// File: rtl/out_port_arb.sv
// Output-port arbiter: round-robin selection among East, South and Local
// input FIFOs into a single output register feeding the downstream FIFO.
// Pops the winning FIFO combinationally in the cycle the register accepts
// its flit, so back-to-back transfers run at one flit per cycle.
module out_port_arb #(
    parameter int DATASIZE = 40
) (
    input  logic                fifo_clk,
    input  logic                rst_n,

    input  logic [DATASIZE-1:0] E_data_in,
    input  logic                E_valid_in,
    input  logic                E_req_in,
    output logic                fifo_ready_E,

    input  logic [DATASIZE-1:0] S_data_in,
    input  logic                S_valid_in,
    input  logic                S_req_in,
    output logic                fifo_ready_S,

    input  logic [DATASIZE-1:0] L_data_in,
    input  logic                L_valid_in,
    input  logic                L_req_in,
    output logic                fifo_ready_L,

    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    input  logic                full_in,
    output logic [1:0]          grant_out
);

    localparam logic [1:0] SRC_E    = 2'd0;
    localparam logic [1:0] SRC_S    = 2'd1;
    localparam logic [1:0] SRC_L    = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    logic                out_vld_q, out_vld_d;
    logic [DATASIZE-1:0] data_q, data_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;

    logic [2:0]          elig;
    logic                drain;
    logic                load_ok;
    logic [1:0]          ptr_eff;
    logic [1:0]          win;

    // Bit order matches the source encoding: [0]=E, [1]=S, [2]=L.
    assign elig      = {L_valid_in & L_req_in, S_valid_in & S_req_in, E_valid_in & E_req_in};
    assign valid_out = out_vld_q & ~full_in;
    assign drain     = valid_out;
    // rst_n gate keeps the pop strobes quiet while reset is held, since the
    // cleared register would otherwise look free to load.
    assign load_ok   = rst_n & (~out_vld_q | drain);
    // An illegal pointer value of 3 falls back to East first.
    assign ptr_eff   = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;

    // Pick the first eligible source at or after the pointer, wrapping L -> E.
    always_comb begin
        win = SRC_NONE;
        case (ptr_eff)
            2'd0: begin
                if      (elig[0]) win = SRC_E;
                else if (elig[1]) win = SRC_S;
                else if (elig[2]) win = SRC_L;
            end
            2'd1: begin
                if      (elig[1]) win = SRC_S;
                else if (elig[2]) win = SRC_L;
                else if (elig[0]) win = SRC_E;
            end
            default: begin
                if      (elig[2]) win = SRC_L;
                else if (elig[0]) win = SRC_E;
                else if (elig[1]) win = SRC_S;
            end
        endcase
    end

    // Pop strobe only to the winner, and only when the register can take it.
    always_comb begin
        fifo_ready_E = load_ok & (win == SRC_E);
        fifo_ready_S = load_ok & (win == SRC_S);
        fifo_ready_L = load_ok & (win == SRC_L);
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_vld_d = out_vld_q;
        data_d    = data_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        if (load_ok && (win != SRC_NONE)) begin
            out_vld_d = 1'b1;
            grant_d   = win;
            case (win)
                SRC_E:   begin data_d = E_data_in; rr_ptr_d = 2'd1; end
                SRC_S:   begin data_d = S_data_in; rr_ptr_d = 2'd2; end
                default: begin data_d = L_data_in; rr_ptr_d = 2'd0; end
            endcase
        end else if (drain) begin
            // Data is deliberately left in place after a drain.
            out_vld_d = 1'b0;
            grant_d   = SRC_NONE;
        end
    end

    // State registers; reset discards any held flit.
    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            data_q    <= '0;
            grant_q   <= SRC_NONE;
            rr_ptr_q  <= 2'd0;
        end else begin
            out_vld_q <= out_vld_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign data_out  = data_q;
    assign grant_out = grant_q;

endmodule

// File: tb/tb_out_port_arb.sv
// Self-checking bench for out_port_arb: directed scenarios plus randomized
// traffic, compared cycle by cycle against a behavioural model.
module tb_out_port_arb;

    localparam int DW = 40;

    logic          fifo_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic [DW-1:0] E_data_in, S_data_in, L_data_in;
    logic          E_valid_in, E_req_in, S_valid_in, S_req_in, L_valid_in, L_req_in;
    logic          fifo_ready_E, fifo_ready_S, fifo_ready_L;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full_in;
    logic [1:0]    grant_out;

    out_port_arb #(.DATASIZE(DW)) dut (
        .fifo_clk     (fifo_clk),
        .rst_n        (rst_n),
        .E_data_in    (E_data_in),
        .E_valid_in   (E_valid_in),
        .E_req_in     (E_req_in),
        .fifo_ready_E (fifo_ready_E),
        .S_data_in    (S_data_in),
        .S_valid_in   (S_valid_in),
        .S_req_in     (S_req_in),
        .fifo_ready_S (fifo_ready_S),
        .L_data_in    (L_data_in),
        .L_valid_in   (L_valid_in),
        .L_req_in     (L_req_in),
        .fifo_ready_L (fifo_ready_L),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full_in      (full_in),
        .grant_out    (grant_out)
    );

    always #5 fifo_clk = ~fifo_clk;

    // Reference model state: what the output register should hold.
    logic          m_vld;
    logic [DW-1:0] m_data;
    logic [1:0]    m_grant;
    int            m_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] src_data(input int s);
        if (s == 0) return E_data_in;
        if (s == 1) return S_data_in;
        return L_data_in;
    endfunction

    // First eligible source scanning from the pointer with wrap; 3 = none.
    function automatic int model_winner();
        logic [2:0] el;
        int c;
        el = {L_valid_in && L_req_in, S_valid_in && S_req_in, E_valid_in && E_req_in};
        for (int k = 0; k < 3; k++) begin
            c = (m_ptr + k) % 3;
            if (el[c]) return c;
        end
        return 3;
    endfunction

    task automatic set_in(input logic [2:0] v, input logic [2:0] r, input logic full);
        {L_valid_in, S_valid_in, E_valid_in} = v;
        {L_req_in,   S_req_in,   E_req_in}   = r;
        full_in   = full;
        E_data_in = rnd_data();
        S_data_in = rnd_data();
        L_data_in = rnd_data();
    endtask

    // Check every output against the model, then advance one clock.
    task automatic step();
        logic          vo, ld;
        int            w;
        logic [2:0]    exp_rdy;
        logic [DW-1:0] wd;
        #1;
        vo = m_vld && !full_in;
        ld = !m_vld || vo;
        w  = ld ? model_winner() : 3;
        exp_rdy = (w == 3) ? 3'b000 : 3'(1 << w);
        wd = src_data(w);
        check("valid_out",  64'(valid_out), 64'(vo));
        check("data_out",   64'(data_out),  64'(m_data));
        check("grant_out",  64'(grant_out), 64'(m_grant));
        check("fifo_ready", 64'({fifo_ready_L, fifo_ready_S, fifo_ready_E}), 64'(exp_rdy));
        @(posedge fifo_clk);
        if (w != 3) begin
            m_vld = 1'b1; m_data = wd; m_grant = 2'(w); m_ptr = (w + 1) % 3;
        end else if (vo) begin
            m_vld = 1'b0; m_grant = 2'd3;
        end
        @(negedge fifo_clk);
    endtask

    // Assert reset at a falling edge with all inputs eligible, check the
    // reset values and silent pop strobes, release one cycle later.
    task automatic apply_reset(input string tag);
        set_in(3'b111, 3'b111, 1'b0);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 64'(valid_out), 64'd0);
        check({tag, "_rst_grant"}, 64'(grant_out), 64'd3);
        check({tag, "_rst_data"},  64'(data_out),  64'd0);
        check({tag, "_rst_ready"}, 64'({fifo_ready_L, fifo_ready_S, fifo_ready_E}), 64'd0);
        m_vld = 1'b0; m_data = '0; m_grant = 2'd3; m_ptr = 0;
        @(posedge fifo_clk);
        @(negedge fifo_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [1:0]    exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        set_in(3'b000, 3'b000, 1'b0);
        m_vld = 1'b0; m_data = '0; m_grant = 2'd3; m_ptr = 0;
        @(negedge fifo_clk);

        // Single flit from East with a fixed payload.
        apply_reset("single");
        set_in(3'b001, 3'b001, 1'b0);
        E_data_in = 40'h12_3456_789A;
        #1 check("single_readyE", 64'(fifo_ready_E), 64'd1);
        step();
        set_in(3'b000, 3'b000, 1'b0);
        #1;
        check("single_valid", 64'(valid_out), 64'd1);
        check("single_data",  64'(data_out),  64'h12_3456_789A);
        check("single_grant", 64'(grant_out), 64'd0);
        step();
        step();

        // Fairness: all three continuously eligible.
        apply_reset("fair");
        for (int i = 0; i < 6; i++) begin
            set_in(3'b111, 3'b111, 1'b0);
            step();
            #1;
            check("fair_grant", 64'(grant_out), 64'(exp_seq[i]));
            check("fair_valid", 64'(valid_out), 64'd1);
        end
        set_in(3'b000, 3'b000, 1'b0);
        step();

        // Backpressure: hold a South flit for four full cycles.
        apply_reset("bp");
        set_in(3'b010, 3'b010, 1'b0);
        held = S_data_in;
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(3'b011, 3'b011, 1'b1);
            #1;
            check("bp_valid", 64'(valid_out), 64'd0);
            check("bp_data",  64'(data_out),  64'(held));
            check("bp_ready", 64'({fifo_ready_L, fifo_ready_S, fifo_ready_E}), 64'd0);
            step();
        end
        set_in(3'b011, 3'b011, 1'b0);
        #1;
        check("bp_release_valid", 64'(valid_out),    64'd1);
        check("bp_release_readyE", 64'(fifo_ready_E), 64'd1);
        step();
        set_in(3'b000, 3'b000, 1'b0);
        step();

        // Wrap: pointer at L with only East eligible, then pointer at S.
        apply_reset("wrap");
        set_in(3'b010, 3'b010, 1'b0);
        step();
        set_in(3'b000, 3'b000, 1'b0);
        step();
        set_in(3'b001, 3'b001, 1'b0);
        #1 check("wrap_readyE", 64'(fifo_ready_E), 64'd1);
        step();
        set_in(3'b011, 3'b011, 1'b0);
        #1 check("wrap_next_readyS", 64'(fifo_ready_S), 64'd1);
        step();
        set_in(3'b000, 3'b000, 1'b0);
        step();

        // Valid but not routed here: never popped, never forwarded.
        apply_reset("nonroute");
        for (int i = 0; i < 5; i++) begin
            set_in(3'b010, 3'b000, 1'b0);
            #1;
            check("nonroute_readyS", 64'(fifo_ready_S), 64'd0);
            check("nonroute_valid",  64'(valid_out),    64'd0);
            step();
        end

        // Reset while a stalled flit is held; East must win first afterwards.
        set_in(3'b010, 3'b010, 1'b0);
        step();
        set_in(3'b111, 3'b111, 1'b1);
        step();
        apply_reset("midstall");
        set_in(3'b111, 3'b111, 1'b0);
        #1 check("midstall_first_readyE", 64'(fifo_ready_E), 64'd1);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(3'($urandom), 3'($urandom | $urandom), ($urandom_range(0, 3) == 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
